// File: rtl/route_pkg.sv
// Shared constants for the route_sched crossbar: select codes,
// FSM state encoding and port counts.
package route_pkg;

  localparam int N_IN  = 6;
  localparam int N_OUT = 7;

  localparam logic [3:0] SEL_LOW       = 4'd0;
  localparam logic [3:0] SEL_HIGH      = 4'd1;
  localparam logic [3:0] SEL_CLK       = 4'd2;
  localparam logic [3:0] SEL_PASS_BASE = 4'd3;
  localparam logic [3:0] SEL_SWAP_BASE = 4'd9;
  localparam logic [3:0] SEL_RSVD      = 4'd15;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

endpackage

// File: rtl/route_lane.sv
// One crossbar lane: decodes a 4-bit select into an (o0, o180) pair
// from the rising and falling input sample vectors.
module route_lane
  import route_pkg::*;
(
  input  logic [3:0]    sel,
  input  logic [N_IN:1] in0,
  input  logic [N_IN:1] in180,
  output logic          o0,
  output logic          o180
);

  logic [3:0] d;

  always_comb begin
    o0   = 1'b0;
    o180 = 1'b0;
    d    = '0;
    unique case (1'b1)
      (sel == SEL_HIGH): begin
        o0   = 1'b1;
        o180 = 1'b1;
      end
      (sel == SEL_CLK): begin
        o180 = 1'b1;
      end
      (sel >= SEL_PASS_BASE && sel < SEL_SWAP_BASE): begin
        d    = sel - (SEL_PASS_BASE - 4'd1);
        o0   = in0[d[2:0]];
        o180 = in180[d[2:0]];
      end
      (sel >= SEL_SWAP_BASE && sel < SEL_RSVD): begin
        d    = sel - (SEL_SWAP_BASE - 4'd1);
        o0   = in180[d[2:0]];
        o180 = in0[d[2:0]];
      end
      default: begin
        o0   = 1'b0;
        o180 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/route_sched.sv
// Runtime-configurable 6-in/7-out DDR sample crossbar with a shadow
// select table applied atomically after an output blanking interval.
module route_sched
  import route_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N_IN:1]  in_diff_0,
  input  logic [N_IN:1]  in_diff_180,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_out,
  input  logic [3:0]     cfg_sel,
  input  logic           cfg_commit,
  output logic           busy,
  output logic           cfg_err,
  output logic [N_OUT:1] out_diff_0,
  output logic [N_OUT:1] out_diff_180
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       shadow [1:N_OUT];
  logic [3:0]       active [1:N_OUT];
  logic [N_OUT:1]   lane0;
  logic [N_OUT:1]   lane180;
  logic             acc;
  logic             bad;

  assign cfg_ready = (state == IDLE);
  assign busy      = ~cfg_ready;
  assign acc       = cfg_valid & cfg_ready;
  assign bad       = (cfg_out == 3'd0) || (cfg_sel == SEL_RSVD);

  for (genvar i = 1; i <= N_OUT; i++) begin : g_lane
    route_lane u_lane (
      .sel   (active[i]),
      .in0   (in_diff_0),
      .in180 (in_diff_180),
      .o0    (lane0[i]),
      .o180  (lane180[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_commit) begin
            state <= BLANK;
            cnt   <= '0;
          end
        end
        BLANK: begin
          if (cnt == LAST) begin
            state <= APPLY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        APPLY: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A write in the commit cycle lands in shadow before APPLY copies it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int i = 1; i <= N_OUT; i++) begin
        shadow[i] <= SEL_LOW;
        active[i] <= SEL_LOW;
      end
    end else begin
      if (acc) begin
        if (bad) cfg_err <= 1'b1;
        else     shadow[cfg_out] <= cfg_sel;
      end
      if (state == APPLY) begin
        for (int i = 1; i <= N_OUT; i++) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_diff_0   <= '0;
      out_diff_180 <= '0;
    end else if (state == IDLE) begin
      out_diff_0   <= lane0;
      out_diff_180 <= lane180;
    end else begin
      out_diff_0   <= '0;
      out_diff_180 <= '0;
    end
  end

endmodule

// File: tb/tb_route_sched.sv
// Self-checking bench for route_sched: table-driven vectors plus
// hand-written commit, error, blanking and reset sequences.
module tb_route_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:1] in_diff_0, in_diff_180;
  logic       cfg_valid, cfg_ready, cfg_commit, busy, cfg_err;
  logic [2:0] cfg_out;
  logic [3:0] cfg_sel;
  logic [7:1] out_diff_0, out_diff_180;

  route_sched #(.BLANK_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_diff_0(in_diff_0), .in_diff_180(in_diff_180),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_out(cfg_out), .cfg_sel(cfg_sel),
    .cfg_commit(cfg_commit), .busy(busy), .cfg_err(cfg_err),
    .out_diff_0(out_diff_0), .out_diff_180(out_diff_180)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:1] i0;
    logic [6:1] i180;
    logic [7:1] e0;
    logic [7:1] e180;
  } vec_t;

  typedef struct packed {
    logic [7:1] e0;
    logic [7:1] e180;
  } exp_t;

  vec_t       vecs [6];
  exp_t       sbq [$];
  logic [3:0] mdl_sh  [1:7];
  logic [3:0] mdl_act [1:7];
  logic       mdl_err;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] mlane(logic [3:0] s, logic [6:1] a,
                                       logic [6:1] b);
    int k;
    if (s == 4'd1) return 2'b11;
    if (s == 4'd2) return 2'b01;
    if (s >= 4'd3 && s <= 4'd8) begin
      k = int'(s) - 2;
      return {a[k], b[k]};
    end
    if (s >= 4'd9 && s <= 4'd14) begin
      k = int'(s) - 8;
      return {b[k], a[k]};
    end
    return 2'b00;
  endfunction

  function automatic exp_t mexp(logic [6:1] a, logic [6:1] b);
    exp_t       e;
    logic [1:0] t;
    e = '0;
    for (int o = 1; o <= 7; o++) begin
      t        = mlane(mdl_act[o], a, b);
      e.e0[o]   = t[1];
      e.e180[o] = t[0];
    end
    return e;
  endfunction

  task automatic mdl_write(input logic [2:0] o, input logic [3:0] s);
    if (o == 3'd0 || s == 4'd15) mdl_err = 1'b1;
    else mdl_sh[int'(o)] = s;
  endtask

  task automatic mdl_clear();
    for (int i = 1; i <= 7; i++) begin
      mdl_sh[i]  = 4'd0;
      mdl_act[i] = 4'd0;
    end
    mdl_err = 1'b0;
  endtask

  task automatic sb_push_tick(input exp_t e);
    exp_t x;
    sbq.push_back(e);
    tick();
    x = sbq.pop_front();
    chk("sb_out0", 32'(out_diff_0), 32'(x.e0));
    chk("sb_out180", 32'(out_diff_180), 32'(x.e180));
  endtask

  task automatic sb_step(input logic [6:1] a, input logic [6:1] b);
    in_diff_0   = a;
    in_diff_180 = b;
    sb_push_tick(mexp(a, b));
  endtask

  task automatic wr(input logic [2:0] o, input logic [3:0] s);
    chk("ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_out   = o;
    cfg_sel   = s;
    mdl_write(o, s);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit(input bit ww, input logic [2:0] wo,
                           input logic [3:0] ws, input bit poke);
    int nb;
    cfg_commit = 1'b1;
    if (ww) begin
      cfg_valid = 1'b1;
      cfg_out   = wo;
      cfg_sel   = ws;
      mdl_write(wo, ws);
    end
    tick();
    cfg_commit = 1'b0;
    cfg_valid  = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      if (nb > 0)
        chk("blank_out", 32'({out_diff_0, out_diff_180}), 32'd0);
      if (poke && nb == 1) begin
        chk("ready_in_blank", 32'(cfg_ready), 32'd0);
        cfg_valid  = 1'b1;
        cfg_out    = 3'd1;
        cfg_sel    = 4'd1;
        cfg_commit = 1'b1;
      end
      tick();
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      nb++;
    end
    chk("busy_len", 32'(nb), 32'd5);
    chk("post_blank_out", 32'({out_diff_0, out_diff_180}), 32'd0);
    for (int i = 1; i <= 7; i++) mdl_act[i] = mdl_sh[i];
  endtask

  initial begin
    rst         = 1'b1;
    in_diff_0   = '0;
    in_diff_180 = '0;
    cfg_valid   = 1'b0;
    cfg_commit  = 1'b0;
    cfg_out     = '0;
    cfg_sel     = '0;
    mdl_clear();

    // Table for out1..7 = 0,1,2,3,8,9,14
    vecs[0] = '{6'b000000, 6'b000000, 7'b0000010, 7'b0000110};
    vecs[1] = '{6'b111111, 6'b000000, 7'b0011010, 7'b1100110};
    vecs[2] = '{6'b000000, 6'b111111, 7'b1100010, 7'b0011110};
    vecs[3] = '{6'b100000, 6'b000001, 7'b0110010, 7'b1001110};
    vecs[4] = '{6'b011110, 6'b011110, 7'b0000010, 7'b0000110};
    vecs[5] = '{6'b000001, 6'b100000, 7'b1001010, 7'b0110110};

    repeat (3) begin
      in_diff_0   = 6'($urandom);
      in_diff_180 = 6'($urandom);
      @(negedge clk);
    end
    chk("rst_out", 32'({out_diff_0, out_diff_180}), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_diff_0   = ~in_diff_0;
      in_diff_180 = 6'($urandom);
      tick();
      chk("idle_out_zero", 32'({out_diff_0, out_diff_180}), 32'd0);
    end
    chk("idle_busy", 32'(busy), 32'd0);

    wr(3'd7, 4'd7);
    in_diff_0   = 6'b010000;
    in_diff_180 = 6'b000000;
    do_commit(1'b0, 3'd0, 4'd0, 1'b0);
    sb_step(6'b010000, 6'b000000);
    chk("out7_pair", 32'({out_diff_0[7], out_diff_180[7]}), 32'b10);
    sb_step(6'b000000, 6'b010000);
    chk("out7_track", 32'({out_diff_0[7], out_diff_180[7]}), 32'b01);

    wr(3'd3, 4'd2);
    wr(3'd2, 4'd13);
    do_commit(1'b0, 3'd0, 4'd0, 1'b0);
    sb_step(6'b010000, 6'b000000);
    chk("out3_clk", 32'({out_diff_0[3], out_diff_180[3]}), 32'b01);
    chk("out2_swap", 32'({out_diff_0[2], out_diff_180[2]}), 32'b01);

    wr(3'd0, 4'd5);
    chk("err_out0", 32'(cfg_err), 32'd1);
    wr(3'd4, 4'd15);
    wr(3'd6, 4'd1);
    chk("err_sticky", 32'(cfg_err), 32'(mdl_err));
    do_commit(1'b0, 3'd0, 4'd0, 1'b0);
    sb_step(6'b111111, 6'b111111);
    chk("out4_unchanged", 32'({out_diff_0[4], out_diff_180[4]}), 32'b00);
    chk("out6_high", 32'({out_diff_0[6], out_diff_180[6]}), 32'b11);

    do_commit(1'b0, 3'd0, 4'd0, 1'b1);
    sb_step(6'($urandom), 6'($urandom));
    chk("out1_nowrite", 32'({out_diff_0[1], out_diff_180[1]}), 32'b00);

    do_commit(1'b1, 3'd5, 4'd3, 1'b0);
    sb_step(6'b000001, 6'b000000);
    chk("wr_with_commit", 32'({out_diff_0[5], out_diff_180[5]}), 32'b10);

    wr(3'd1, 4'd0);
    wr(3'd2, 4'd1);
    wr(3'd3, 4'd2);
    wr(3'd4, 4'd3);
    wr(3'd5, 4'd8);
    wr(3'd6, 4'd9);
    wr(3'd7, 4'd14);
    do_commit(1'b0, 3'd0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_diff_0   = vecs[i].i0;
      in_diff_180 = vecs[i].i180;
      sb_push_tick('{e0: vecs[i].e0, e180: vecs[i].e180});
    end

    wr(3'd4, 4'd1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_out", 32'({out_diff_0, out_diff_180}), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
    chk("rst_mid_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    do_commit(1'b0, 3'd0, 4'd0, 1'b0);
    sb_step(6'b111111, 6'b000000);
    chk("out4_cleared", 32'({out_diff_0[4], out_diff_180[4]}), 32'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
